// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter
//   Two-requester round-robin arbiter driving a classic T1/T2/T3/TW/T4 bus
//   cycle. The winning request is latched when it leaves IDLE, the bus
//   strobes follow the state machine, and a per-requester DONE pulse
//   closes each cycle. A slave that never asserts READY is cut off after
//   MAX_WAIT wait states and the cycle completes with ERR set.
//
// Ports
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   REQ, REQ_WR, REQ_IOM  per-requester request level, write select, IO/mem
//   REQ_ADDR0/1           requester addresses
//   REQ_WDATA0/1          requester write data
//   GNT, DONE, ERR        grant pulse, completion pulse, timeout flag
//   RDATA                 read result, valid from DONE until the next DONE
//   ALE, IOM, RD, WR      bus strobes (RD, WR active-low)
//   Address, data_out     bus address, bus write data
//   DEN                   write data enable
//   data_in, READY        bus read data, slave ready (sampled in T3/TW)
module bus_cycle_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            REQ,
  input  logic [1:0]            REQ_WR,
  input  logic [1:0]            REQ_IOM,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR0,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR1,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA0,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA1,
  output logic [1:0]            GNT,
  output logic [1:0]            DONE,
  output logic                  ERR,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  ALE,
  output logic                  IOM,
  output logic                  RD,
  output logic                  WR,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  DEN,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  READY
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t                  state_q, state_d;
  logic                    last_q;
  logic                    win_q, win_d;
  logic                    wr_q, wr_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic                    tout_q, tout_d;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    pick_d;
  logic                    strobe_d;

  logic [1:0]              gnt_q, done_q;
  logic                    err_q, ale_q, iom_q, rd_q, wrs_q, den_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   dout_q;

  always_comb begin
    // On contention the requester that did not win last time goes next.
    pick_d  = (REQ == 2'b11) ? ~last_q : REQ[1];
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tout_d  = tout_q;
    win_d   = win_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (REQ != 2'b00) begin
          state_d = S_T1;
          tout_d  = 1'b0;
          win_d   = pick_d;
          wr_d    = REQ_WR[pick_d];
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        if (READY) begin
          state_d = S_T4;
        end else begin
          state_d = S_TW;
          wcnt_d  = 4'd0;
        end
      end
      S_TW: begin
        if (READY) begin
          state_d = S_T4;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
          if (wcnt_q + 4'd1 == WAIT_LIMIT) begin
            state_d = S_T4;
            tout_d  = 1'b1;
          end
        end
      end
      S_T4:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Read data lands on the edge that leaves T3/TW; a timed-out read
    // returns all ones so the requester never sees stale data.
    if (!wr_q && (state_q == S_T3 || state_q == S_TW)) begin
      if (READY) begin
        rdata_d = data_in;
      end else if (state_d == S_T4) begin
        rdata_d = '1;
      end
    end
    strobe_d = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_TW);
  end

  // Outputs are computed from the next state so they line up with state_q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      wcnt_q  <= 4'd0;
      tout_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      ale_q   <= 1'b0;
      iom_q   <= 1'b0;
      rd_q    <= 1'b1;
      wrs_q   <= 1'b1;
      den_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      wcnt_q  <= wcnt_d;
      tout_q  <= tout_d;
      rdata_q <= rdata_d;
      if (state_q == S_IDLE && REQ != 2'b00) begin
        last_q  <= pick_d;
        iom_q   <= REQ_IOM[pick_d];
        addr_q  <= pick_d ? REQ_ADDR1 : REQ_ADDR0;
        wdata_q <= pick_d ? REQ_WDATA1 : REQ_WDATA0;
      end
      gnt_q  <= (state_d == S_T1) ? (2'b01 << win_d) : 2'b00;
      done_q <= (state_d == S_T4) ? (2'b01 << win_d) : 2'b00;
      err_q  <= (state_d == S_T4) & tout_d;
      ale_q  <= (state_d == S_T1);
      rd_q   <= ~(strobe_d & ~wr_d);
      wrs_q  <= ~(strobe_d & wr_d);
      den_q  <= strobe_d & wr_d;
      if (strobe_d && wr_d) begin
        dout_q <= wdata_q;
      end
    end
  end

  assign GNT      = gnt_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign ALE      = ale_q;
  assign IOM      = iom_q;
  assign RD       = rd_q;
  assign WR       = wrs_q;
  assign Address  = addr_q;
  assign data_out = dout_q;
  assign DEN      = den_q;

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// tb_bus_cycle_arbiter
//   Directed bus cycles followed by randomized traffic, all checked against
//   a transaction-level reference model of the arbiter and bus cycle.
module tb_bus_cycle_arbiter;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam int MW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [1:0]    REQ = 2'b00, REQ_WR = 2'b00, REQ_IOM = 2'b00;
  logic [AW-1:0] REQ_ADDR0 = '0, REQ_ADDR1 = '0;
  logic [DW-1:0] REQ_WDATA0 = '0, REQ_WDATA1 = '0, data_in = '0;
  logic          READY = 1'b1;
  logic [1:0]    GNT, DONE;
  logic          ERR, ALE, IOM, RD, WR, DEN;
  logic [DW-1:0] RDATA, data_out;
  logic [AW-1:0] Address;

  bus_cycle_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_IOM(REQ_IOM),
    .REQ_ADDR0(REQ_ADDR0), .REQ_ADDR1(REQ_ADDR1),
    .REQ_WDATA0(REQ_WDATA0), .REQ_WDATA1(REQ_WDATA1),
    .GNT(GNT), .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .ALE(ALE), .IOM(IOM),
    .RD(RD), .WR(WR), .Address(Address), .data_out(data_out), .DEN(DEN),
    .data_in(data_in), .READY(READY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: position within the bus cycle.
  // 0 = no cycle, 1 = grant/address cycle, 2 = first strobe cycle,
  // 3.. = cycles in which READY is looked at, 99 = completion cycle.
  // A cycle may look at READY at most 1+MW times before timing out.
  int            m_ph = 0;
  bit            m_last = 1'b1, m_win = 1'b0, m_wr = 1'b0, m_iom = 1'b0, m_tout = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;

  // Event log of what the DUT actually did, for the directed checks.
  int            cyc = 0;
  int            g_idx[$], g_cyc[$], d_idx[$], d_cyc[$], d_err[$];
  logic [DW-1:0] d_rd[$];
  logic [AW-1:0] g_addr[$];
  int            rd_lo = 0, wr_lo = 0, den_match = 0, iom_hi = 0;
  bit            in_txn = 1'b0;
  logic [DW-1:0] exp_dout = '0;

  logic [1:0]    e_gnt, e_done;
  bit            e_strobe;

  always begin
    @(posedge CLK);
    cyc++;
    if (RESET) begin
      m_ph = 0; m_last = 1'b1; m_rdata = '0; m_addr = '0; m_iom = 1'b0; m_tout = 1'b0;
    end else if (m_ph == 99) begin
      m_ph = 0;
    end else if (m_ph == 0) begin
      if (REQ != 2'b00) begin
        m_win   = (REQ == 2'b11) ? !m_last : REQ[1];
        m_last  = m_win;
        m_wr    = REQ_WR[m_win];
        m_iom   = REQ_IOM[m_win];
        m_addr  = m_win ? REQ_ADDR1 : REQ_ADDR0;
        m_wdata = m_win ? REQ_WDATA1 : REQ_WDATA0;
        m_tout  = 1'b0;
        m_ph    = 1;
      end
    end else if (m_ph < 3) begin
      m_ph++;
    end else begin
      if (READY) begin
        if (!m_wr) m_rdata = data_in;
        m_ph = 99;
      end else if (m_ph - 2 == MW + 1) begin
        m_tout = 1'b1;
        if (!m_wr) m_rdata = '1;
        m_ph = 99;
      end else begin
        m_ph++;
      end
    end
    #1;
    e_gnt    = (m_ph == 1)  ? (2'b01 << m_win) : 2'b00;
    e_done   = (m_ph == 99) ? (2'b01 << m_win) : 2'b00;
    e_strobe = (m_ph >= 2) && (m_ph != 99);
    chk("GNT", GNT, e_gnt);
    chk("DONE", DONE, e_done);
    chk("ERR", ERR, (m_ph == 99) && m_tout);
    chk("ALE", ALE, m_ph == 1);
    chk("RD", RD, !(e_strobe && !m_wr));
    chk("WR", WR, !(e_strobe && m_wr));
    chk("DEN", DEN, e_strobe && m_wr);
    if (e_strobe && m_wr) chk("data_out", data_out, m_wdata);
    chk("Address", Address, m_addr);
    chk("IOM", IOM, m_iom);
    chk("RDATA", RDATA, m_rdata);
    chk("RD_WR_both_low", (RD == 1'b0) && (WR == 1'b0), 0);
    chk("ALE_with_strobe", ALE && (!RD || !WR), 0);
    if (GNT != 2'b00) begin
      g_idx.push_back(int'(GNT[1])); g_cyc.push_back(cyc); g_addr.push_back(Address);
      in_txn = 1'b1;
    end
    if (!RD) rd_lo++;
    if (!WR) wr_lo++;
    if (!WR && DEN && data_out == exp_dout) den_match++;
    if (in_txn && IOM) iom_hi++;
    if (DONE != 2'b00) begin
      d_idx.push_back(int'(DONE[1])); d_cyc.push_back(cyc); d_err.push_back(int'(ERR));
      d_rd.push_back(RDATA);
      in_txn = 1'b0;
    end
    if (RESET) in_txn = 1'b0;
  end

  bit rdy_rand  = 1'b0;
  int rdy_delay = 0;
  int pend[2];
  bit ok;

  task automatic tick();
    @(negedge CLK);
    if (rdy_rand) READY = 1'($urandom_range(0, 1));
    else READY = (m_ph >= 3 && m_ph != 99) ? ((m_ph - 3) >= rdy_delay) : 1'b1;
  endtask

  task automatic clear_log();
    g_idx.delete(); g_cyc.delete(); g_addr.delete();
    d_idx.delete(); d_cyc.delete(); d_err.delete(); d_rd.delete();
    rd_lo = 0; wr_lo = 0; den_match = 0; iom_hi = 0;
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Cycles from the IDLE cycle in which REQ is sampled through the DONE cycle.
  function automatic int lat(input int i);
    return (i < d_cyc.size() && i < g_cyc.size()) ? d_cyc[i] - g_cyc[i] + 2 : -1;
  endfunction

  task automatic do_txn(input int r, output bit done_ok);
    int n0;
    n0 = d_idx.size();
    done_ok = 1'b0;
    REQ[r] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (GNT[r]) REQ[r] = 1'b0;
      if (d_idx.size() > n0) begin
        done_ok = 1'b1;
        break;
      end
    end
    REQ[r] = 1'b0;
    if (!done_ok) chk("txn_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    RESET = 1'b0;
    tick();

    // Requester 0 read, no wait states
    clear_log();
    REQ_WR = 2'b00; REQ_ADDR0 = 20'h00010; data_in = 8'h5A; rdy_delay = 0;
    do_txn(0, ok);
    chk("t1_grants", g_idx.size(), 1);
    chk("t1_gnt_idx", qi(g_idx, 0), 0);
    chk("t1_addr", g_addr.size() > 0 ? g_addr[0] : '1, 20'h00010);
    chk("t1_rd_low_cycles", rd_lo, 2);
    chk("t1_latency", lat(0), 5);
    chk("t1_done_idx", qi(d_idx, 0), 0);
    chk("t1_err", qi(d_err, 0), 0);
    chk("t1_rdata", d_rd.size() > 0 ? d_rd[0] : 8'h00, 8'h5A);

    // Requester 1 write to IO space
    clear_log();
    REQ_WR = 2'b10; REQ_IOM = 2'b10; REQ_WDATA1 = 8'hC3; REQ_ADDR1 = 20'hABCDE;
    exp_dout = 8'hC3;
    do_txn(1, ok);
    chk("t2_wr_low_cycles", wr_lo, 2);
    chk("t2_den_data_cycles", den_match, 2);
    chk("t2_rd_low_cycles", rd_lo, 0);
    chk("t2_iom_high_cycles", iom_hi, 4);
    chk("t2_done_idx", qi(d_idx, 0), 1);
    chk("t2_err", qi(d_err, 0), 0);
    chk("t2_latency", lat(0), 5);
    chk("t2_addr", g_addr.size() > 0 ? g_addr[0] : '0, 20'hABCDE);
    chk("t2_rdata_kept", d_rd.size() > 0 ? d_rd[0] : 8'h00, 8'h5A);

    // Contention right after reset: 0 wins first, then alternation
    RESET = 1'b1; tick(); tick(); RESET = 1'b0;
    clear_log();
    REQ_WR = 2'b00; REQ_IOM = 2'b00;
    pend[0] = 2; pend[1] = 1;
    REQ = 2'b11;
    for (int i = 0; i < 200; i++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (GNT[r]) begin
          pend[r]--;
          REQ[r] = (pend[r] > 0);
        end
      end
      if (d_idx.size() >= 3) break;
    end
    REQ = 2'b00;
    chk("t3_dones", d_idx.size(), 3);
    chk("t3_order0", qi(g_idx, 0), 0);
    chk("t3_order1", qi(g_idx, 1), 1);
    chk("t3_order2", qi(g_idx, 2), 0);
    for (int i = 0; i < 2; i++) begin
      chk("t3_done_before_next_t1", qi(d_cyc, i) < qi(g_cyc, i + 1), 1);
      chk("t3_idle_gap", qi(g_cyc, i + 1) - qi(d_cyc, i), 2);
    end

    // Read with two wait states
    clear_log();
    data_in = 8'h3C; rdy_delay = 2;
    do_txn(0, ok);
    chk("t4_latency", lat(0), 7);
    chk("t4_rd_low_cycles", rd_lo, 4);
    chk("t4_err", qi(d_err, 0), 0);
    chk("t4_rdata", d_rd.size() > 0 ? d_rd[0] : 8'h00, 8'h3C);

    // Read that times out
    clear_log();
    data_in = 8'h11; rdy_delay = 1000;
    do_txn(0, ok);
    chk("t5_latency", lat(0), 9);
    chk("t5_rd_low_cycles", rd_lo, 6);
    chk("t5_err", qi(d_err, 0), 1);
    chk("t5_rdata", d_rd.size() > 0 ? d_rd[0] : 8'h00, 8'hFF);
    rdy_delay = 0;

    // Reset in T3 of a write, then a clean read
    clear_log();
    REQ_WR = 2'b01; REQ_WDATA0 = 8'h77;
    REQ[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (GNT[0]) REQ[0] = 1'b0;
      if (m_ph == 3) break;
    end
    REQ = 2'b00;
    chk("t6_wr_low_in_t3", WR, 0);
    RESET = 1'b1;
    tick();
    chk("t6_wr_after_reset", WR, 1);
    chk("t6_den_after_reset", DEN, 0);
    RESET = 1'b0;
    repeat (5) tick();
    chk("t6_no_done", d_idx.size(), 0);
    REQ_WR = 2'b00; data_in = 8'hA5;
    do_txn(1, ok);
    chk("t6_regrant_idx", qi(g_idx, 1), 1);
    chk("t6_regrant_latency", (d_cyc.size() > 0 && g_cyc.size() > 1) ? d_cyc[0] - g_cyc[1] + 2 : -1, 5);
    chk("t6_regrant_rdata", d_rd.size() > 0 ? d_rd[0] : 8'h00, 8'hA5);

    // Randomized traffic including dropped requests and stray resets
    rdy_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      REQ        = 2'($urandom_range(0, 3));
      REQ_WR     = 2'($urandom_range(0, 3));
      REQ_IOM    = 2'($urandom_range(0, 3));
      REQ_ADDR0  = AW'($urandom);
      REQ_ADDR1  = AW'($urandom);
      REQ_WDATA0 = DW'($urandom);
      REQ_WDATA1 = DW'($urandom);
      data_in    = DW'($urandom);
      RESET      = ($urandom_range(0, 199) == 0);
    end
    rdy_rand = 1'b0;
    RESET = 1'b0; REQ = 2'b00;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
